// File: rtl/sym_vn_lut_multiport.sv
// Multi-port symmetric VN IB-LUT: per-port sign fold, shared flop table, load bitmap.
// Latency 2 cycles, one request per port per cycle, no backpressure.
module sym_vn_lut_multiport #(
  parameter int  QUAN_SIZE = 3,
  parameter int  PORT_NUM  = 4,
  parameter int  FOLD_MODE = 0,
  parameter int  WR_BYPASS = 0,
  localparam int ADDR_W    = 2*QUAN_SIZE-1
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic [PORT_NUM-1:0]           in_valid,
  input  logic [PORT_NUM-1:0]           transpose_en_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
  output logic [PORT_NUM*QUAN_SIZE-1:0] t_c_out,
  output logic [PORT_NUM-1:0]           transpose_en_out,
  output logic [PORT_NUM-1:0]           out_valid,
  input  logic [QUAN_SIZE-1:0]          lut_in,
  input  logic [ADDR_W-1:0]             page_write_addr,
  input  logic                          we,
  input  logic                          load_clr,
  output logic                          lut_ready
);

  localparam int Q     = QUAN_SIZE;
  localparam int DEPTH = 1 << ADDR_W;

  logic [Q-2:0]        y0m_d   [PORT_NUM];
  logic [Q-2:0]        y0m_q   [PORT_NUM];
  logic [Q-1:0]        y1m_d   [PORT_NUM];
  logic [Q-1:0]        y1m_q   [PORT_NUM];
  logic [PORT_NUM-1:0] s0_d, s0_q, v0_q;
  logic [ADDR_W-1:0]   rd_addr [PORT_NUM];
  logic [Q-1:0]        tc_d    [PORT_NUM];
  logic [Q-1:0]        tc_q    [PORT_NUM];
  logic [PORT_NUM-1:0] s1_q, v1_q;
  logic [Q-1:0]        table_q [DEPTH];
  logic [DEPTH-1:0]    bitmap_d, bitmap_q;
  logic                lut_ready_q;

  // Fold the message pair so that only the non-negative y0 half of the table is addressed.
  always_comb begin
    s0_d  = '0;
    y0m_d = '{default: '0};
    y1m_d = '{default: '0};
    for (int p = 0; p < PORT_NUM; p++) begin
      s0_d[p]  = y0_in[p*Q+Q-1] ^ transpose_en_in[p];
      y0m_d[p] = y0_in[p*Q +: Q-1];
      if (FOLD_MODE == 1) begin
        y0m_d[p] = y0m_d[p] ^ {(Q-1){y0_in[p*Q+Q-1]}};
      end
      if (FOLD_MODE == 2) begin
        y1m_d[p] = {y1_in[p*Q+Q-1] ^ s0_d[p], y1_in[p*Q +: Q-1]};
      end else begin
        y1m_d[p] = y1_in[p*Q +: Q] ^ {Q{s0_d[p]}};
      end
    end
  end

  always_comb begin
    rd_addr = '{default: '0};
    tc_d    = '{default: '0};
    for (int p = 0; p < PORT_NUM; p++) begin
      rd_addr[p] = {y0m_q[p], y1m_q[p]};
      tc_d[p]    = table_q[rd_addr[p]];
      if (WR_BYPASS != 0 && we && page_write_addr == rd_addr[p]) begin
        tc_d[p] = lut_in;
      end
    end
  end

  // Clear dominates a coincident write so the bitmap never claims a cleared page is loaded.
  always_comb begin
    bitmap_d = bitmap_q;
    if (load_clr) begin
      bitmap_d = '0;
    end else if (we) begin
      bitmap_d[page_write_addr] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        y0m_q[p] <= '0;
        y1m_q[p] <= '0;
        tc_q[p]  <= '0;
      end
      for (int a = 0; a < DEPTH; a++) begin
        table_q[a] <= '0;
      end
      s0_q        <= '0;
      v0_q        <= '0;
      s1_q        <= '0;
      v1_q        <= '0;
      bitmap_q    <= '0;
      lut_ready_q <= 1'b0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        y0m_q[p] <= y0m_d[p];
        y1m_q[p] <= y1m_d[p];
        tc_q[p]  <= tc_d[p];
      end
      if (we) begin
        table_q[page_write_addr] <= lut_in;
      end
      s0_q        <= s0_d;
      v0_q        <= in_valid;
      s1_q        <= s0_q;
      v1_q        <= v0_q;
      bitmap_q    <= bitmap_d;
      lut_ready_q <= &bitmap_d;
    end
  end

  always_comb begin
    t_c_out = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      t_c_out[p*Q +: Q] = tc_q[p];
    end
  end

  assign transpose_en_out = s1_q;
  assign out_valid        = v1_q;
  assign lut_ready        = lut_ready_q;

endmodule

// File: tb/tb_sym_vn_lut_multiport.sv
// Three DUT copies (fold modes 0/1/2, bypass only on mode 1) share stimulus; a table-level model predicts each.
module tb_sym_vn_lut_multiport;

  logic        clk;
  logic        rstn;
  logic [3:0]  in_valid, te_in;
  logic [11:0] y0, y1;
  logic [2:0]  lut_in;
  logic [4:0]  wa;
  logic        we, load_clr;

  logic [11:0] tco [3];
  logic [3:0]  teo [3];
  logic [3:0]  ov  [3];
  logic        rdy [3];

  int vec_cnt  = 0;
  int fail_cnt = 0;
  bit cmp_en   = 0;

  int mode_of [3] = '{0, 1, 2};
  int byp_of  [3] = '{0, 1, 0};

  sym_vn_lut_multiport #(.QUAN_SIZE(3), .PORT_NUM(4), .FOLD_MODE(0), .WR_BYPASS(0)) u_m0 (
    .sys_clk(clk), .rstn(rstn), .in_valid(in_valid), .transpose_en_in(te_in),
    .y0_in(y0), .y1_in(y1), .t_c_out(tco[0]), .transpose_en_out(teo[0]),
    .out_valid(ov[0]), .lut_in(lut_in), .page_write_addr(wa), .we(we),
    .load_clr(load_clr), .lut_ready(rdy[0]));

  sym_vn_lut_multiport #(.QUAN_SIZE(3), .PORT_NUM(4), .FOLD_MODE(1), .WR_BYPASS(1)) u_m1 (
    .sys_clk(clk), .rstn(rstn), .in_valid(in_valid), .transpose_en_in(te_in),
    .y0_in(y0), .y1_in(y1), .t_c_out(tco[1]), .transpose_en_out(teo[1]),
    .out_valid(ov[1]), .lut_in(lut_in), .page_write_addr(wa), .we(we),
    .load_clr(load_clr), .lut_ready(rdy[1]));

  sym_vn_lut_multiport #(.QUAN_SIZE(3), .PORT_NUM(4), .FOLD_MODE(2), .WR_BYPASS(0)) u_m2 (
    .sys_clk(clk), .rstn(rstn), .in_valid(in_valid), .transpose_en_in(te_in),
    .y0_in(y0), .y1_in(y1), .t_c_out(tco[2]), .transpose_en_out(teo[2]),
    .out_valid(ov[2]), .lut_in(lut_in), .page_write_addr(wa), .we(we),
    .load_clr(load_clr), .lut_ready(rdy[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Page address from the sign-symmetry rules, as plain integer arithmetic.
  function automatic logic [4:0] fold_addr(input int mode, input logic [2:0] a, input logic [2:0] b,
                                           input logic te, output logic s);
    int m0, v1;
    s  = a[2] ^ te;
    m0 = int'(a) % 4;
    if (mode == 1 && a[2]) m0 = 3 - m0;
    v1 = int'(b);
    if (s) v1 = (mode == 2) ? (v1 ^ 4) : (7 - v1);
    return 5'(m0 * 8 + v1);
  endfunction

  logic [2:0]  mem [32];
  logic [31:0] bm;
  logic        rdy_e;
  logic        pv [3][4];
  logic        ps [3][4];
  logic [4:0]  pa [3][4];
  logic        ev [3][4];
  logic        es [3][4];
  logic [2:0]  et [3][4];

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int a = 0; a < 32; a++) mem[a] = '0;
        bm = '0;
        rdy_e = 0;
        for (int i = 0; i < 3; i++)
          for (int p = 0; p < 4; p++) begin
            pv[i][p] = 0; ps[i][p] = 0; pa[i][p] = '0;
            ev[i][p] = 0; es[i][p] = 0; et[i][p] = '0;
          end
      end else begin
        for (int i = 0; i < 3; i++)
          for (int p = 0; p < 4; p++) begin
            ev[i][p] = pv[i][p];
            es[i][p] = ps[i][p];
            et[i][p] = (byp_of[i] != 0 && we && wa == pa[i][p]) ? lut_in : mem[pa[i][p]];
          end
        if (we) mem[wa] = lut_in;
        if (load_clr) bm = '0;
        else if (we) bm[wa] = 1'b1;
        rdy_e = &bm;
        for (int i = 0; i < 3; i++)
          for (int p = 0; p < 4; p++) begin
            pv[i][p] = in_valid[p];
            pa[i][p] = fold_addr(mode_of[i], y0[p*3 +: 3], y1[p*3 +: 3], te_in[p], ps[i][p]);
          end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          for (int p = 0; p < 4; p++) begin
            chk($sformatf("valid i%0d p%0d", i, p), 32'(ov[i][p]), 32'(ev[i][p]));
            if (ev[i][p]) begin
              chk($sformatf("data i%0d p%0d", i, p), 32'(tco[i][p*3 +: 3]), 32'(et[i][p]));
              chk($sformatf("sign i%0d p%0d", i, p), 32'(teo[i][p]), 32'(es[i][p]));
            end
          end
          chk($sformatf("ready i%0d", i), 32'(rdy[i]), 32'(rdy_e));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] d);
    we = 1; wa = a; lut_in = d;
    tick();
    we = 0;
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s valid i%0d", nm, i), 32'(ov[i]), 32'h0);
      chk($sformatf("%s data i%0d", nm, i), 32'(tco[i]), 32'h0);
      chk($sformatf("%s sign i%0d", nm, i), 32'(teo[i]), 32'h0);
      chk($sformatf("%s ready i%0d", nm, i), 32'(rdy[i]), 32'h0);
    end
  endtask

  initial begin
    rstn = 0; in_valid = 0; te_in = 0; y0 = 0; y1 = 0;
    lut_in = 0; wa = 0; we = 0; load_clr = 0;
    repeat (3) tick();
    chk_zero("reset");
    rstn = 1;
    cmp_en = 1;

    // Empty table reads back zero.
    in_valid = 4'hF; y0 = 12'($urandom); y1 = 12'($urandom); te_in = 4'($urandom);
    tick();
    in_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("empty read valid", 32'(ov[i]), 32'hF);
      chk("empty read data", 32'(tco[i]), 32'h0);
    end

    // Directed fold cases.
    wr(5'd13, 3'b110);
    wr(5'd10, 3'b111);
    in_valid = 4'hF;
    y0 = {3'b110, 3'b101, 3'b101, 3'b001};
    y1 = {3'b010, 3'b010, 3'b010, 3'b101};
    te_in = 4'b0100;
    tick();
    in_valid = 0;
    tick();
    chk("basic p0 data", 32'(tco[0][2:0]), 32'h6);
    chk("basic p0 sign", 32'(teo[0][0]), 32'h0);
    chk("basic p0 valid", 32'(ov[0][0]), 32'h1);
    chk("fold p1 data", 32'(tco[0][5:3]), 32'h6);
    chk("fold p1 sign", 32'(teo[0][1]), 32'h1);
    chk("transpose p2 data", 32'(tco[0][8:6]), 32'h7);
    chk("transpose p2 sign", 32'(teo[0][2]), 32'h0);
    chk("mode0 p3 addr21", 32'(tco[0][11:9]), 32'h0);
    chk("mode1 p3 addr13", 32'(tco[1][11:9]), 32'h6);
    chk("mode2 p1 addr14", 32'(tco[2][5:3]), 32'h0);

    // Write/read collision on page 13.
    in_valid = 4'b0001; y0 = 12'b001; y1 = 12'b101; te_in = 0;
    tick();
    in_valid = 0; we = 1; wa = 5'd13; lut_in = 3'b011;
    tick();
    we = 0;
    chk("collision nobyp m0", 32'(tco[0][2:0]), 32'h6);
    chk("collision bypass m1", 32'(tco[1][2:0]), 32'h3);
    chk("collision nobyp m2", 32'(tco[2][2:0]), 32'h6);
    in_valid = 4'b0001;
    tick();
    in_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) chk("after collision", 32'(tco[i][2:0]), 32'h3);

    // All ports in one cycle.
    wr(5'd0, 3'd1); wr(5'd1, 3'd2); wr(5'd2, 3'd3); wr(5'd3, 3'd4);
    in_valid = 4'hF; y0 = 0; y1 = {3'd3, 3'd2, 3'd1, 3'd0}; te_in = 0;
    tick();
    in_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("all ports data", 32'(tco[i]), 32'h8D1);
      chk("all ports valid", 32'(ov[i]), 32'hF);
    end

    // Eight back-to-back requests.
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8) ? 4'hF : 4'h0;
      y0 = 12'($urandom); y1 = 12'($urandom); te_in = 4'($urandom);
      tick();
      if (k >= 1 && k <= 8) chk("stream valid", 32'(ov[0]), 32'hF);
    end

    // Randomized traffic with interleaved writes and occasional clears.
    for (int k = 0; k < 400; k++) begin
      in_valid = 4'($urandom); te_in = 4'($urandom);
      y0 = 12'($urandom); y1 = 12'($urandom);
      we = 1'($urandom); wa = 5'($urandom); lut_in = 3'($urandom);
      load_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 0; we = 0; load_clr = 0;

    // Load tracking.
    load_clr = 1;
    tick();
    load_clr = 0;
    for (int a = 0; a < 32; a++) if (a != 7) wr(5'(a), 3'($urandom));
    tick();
    for (int i = 0; i < 3; i++) chk("ready 31 of 32", 32'(rdy[i]), 32'h0);
    wr(5'd7, 3'd5);
    for (int i = 0; i < 3; i++) chk("ready all written", 32'(rdy[i]), 32'h1);
    load_clr = 1; we = 1; wa = 5'd0; lut_in = 3'd2;
    tick();
    load_clr = 0; we = 0;
    for (int i = 0; i < 3; i++) chk("ready after clr+we", 32'(rdy[i]), 32'h0);
    for (int a = 1; a < 32; a++) wr(5'(a), 3'($urandom));
    tick();
    for (int i = 0; i < 3; i++) chk("clr beat write", 32'(rdy[i]), 32'h0);
    wr(5'd0, 3'd6);
    for (int i = 0; i < 3; i++) chk("ready reloaded", 32'(rdy[i]), 32'h1);

    // Reset in the middle of a stream.
    in_valid = 4'hF; y0 = 12'($urandom); y1 = 12'($urandom);
    repeat (3) tick();
    @(posedge clk);
    #3 rstn = 0;
    #1 chk_zero("midstream reset");
    tick();
    rstn = 1;
    y0 = 12'($urandom); y1 = 12'($urandom); te_in = 4'($urandom);
    tick();
    in_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("post reset data", 32'(tco[i]), 32'h0);
      chk("post reset ready", 32'(rdy[i]), 32'h0);
    end
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_multiport.md
# sym_vn_lut_multiport

- Parametrised successor to the dual-port symmetric variable-node IB-LUT.
- Serves `PORT_NUM` read ports from one shared LUT of `QUAN_SIZE`-bit entries. Each port folds its incoming message pair by sign symmetry into a page address, reads the table and returns the entry plus the transpose (sign) flag two cycles later.
- Adds per-port valid tracking, a selectable sign-fold mode, optional write-to-read bypass and a table-loaded indicator.
- Read and write run on one clock. It sits between the VNU message datapath and the LUT-update loader.

## Interface
Parameters:
- `QUAN_SIZE`, 3, message/entry width; bit `QUAN_SIZE-1` is the sign.
- `PORT_NUM`, 4, number of independent read ports.
- `FOLD_MODE`, 0, input fold:
  - 0: `y0` magnitude passes through; `y1` fully inverted when the folded sign is 1.
  - 1: `y0` magnitude XOR `y0` msb, then as mode 0.
  - 2: `y0` magnitude passes through; only the `y1` msb is XORed with the folded sign.
- `WR_BYPASS`, 0, 1 = same-cycle write data forwarded to a matching stage-1 read.
- `ADDR_W`, `2*QUAN_SIZE-1` (derived, do not override), page address width.

Ports:
- `sys_clk`  in  1  single clock for read and write.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `PORT_NUM`  per-port request valid.
- `transpose_en_in`  in  `PORT_NUM`  per-port transpose enable, XORed into the `y0` sign.
- `y0_in`  in  `PORT_NUM*QUAN_SIZE`  first message; port p occupies bits `[p*QUAN_SIZE +: QUAN_SIZE]`.
- `y1_in`  in  `PORT_NUM*QUAN_SIZE`  second message, same packing.
- `t_c_out`  out  `PORT_NUM*QUAN_SIZE`  LUT result per port.
- `transpose_en_out`  out  `PORT_NUM`  folded sign, delayed to align with `t_c_out`.
- `out_valid`  out  `PORT_NUM`  per-port result valid.
- `lut_in`  in  `QUAN_SIZE`  write data.
- `page_write_addr`  in  `ADDR_W`  write address.
- `we`  in  1  write enable.
- `load_clr`  in  1  clears the written-entry bitmap.
- `lut_ready`  out  1  high when every entry has been written since the last reset or `load_clr`.

## Operation
Stage 0 (combinational on inputs, registered at the edge), per port p:
- `s = y0[Q-1] ^ transpose_en_in[p]`.
- `y0m` = `y0[Q-2:0]`, XORed with `{Q-1{y0[Q-1]}}` in mode 1.
- `y1m` = `y1 ^ {Q{s}}` in modes 0 and 1. In mode 2, `y1m = {y1[Q-1]^s, y1[Q-2:0]}`.
- Registers loaded: `y0m`, `y1m`, `s`, `in_valid[p]`.

Stage 1:
- `addr_p = {y0m, y1m}`.
- The table (`2**ADDR_W` x `QUAN_SIZE` flops) is read combinationally at `addr_p`.
- Registers loaded: result, `s`, valid.
- All ports read concurrently; there are no port conflicts.

Write:
- When `we`, `table[page_write_addr] <= lut_in` at the edge.
- The bit of `page_write_addr` is set in the written bitmap.
- `load_clr` clears the bitmap. If `load_clr` and `we` occur in the same cycle, the clear wins and the written bit stays 0.
- `lut_ready = &bitmap`, registered.

Read/write collision in the same cycle:
- `WR_BYPASS=0`: stage 1 returns the old entry.
- `WR_BYPASS=1`: stage 1 returns `lut_in`.

Invalid requests:
- Still propagate through the pipeline.
- `out_valid` stays 0 for them; `t_c_out` and `transpose_en_out` carry don't-care-but-deterministic values.

## Timing
- Latency: inputs sampled at edge n produce outputs after edge n+1, i.e. valid during cycle n+2. Throughput is one request per port per cycle.
- Reset (async assert, sync-safe release): all pipeline registers, table entries, bitmap, `out_valid`, `t_c_out`, `transpose_en_out` and `lut_ready` go to 0.
- Reset mid-stream: in-flight requests are discarded and `out_valid` drops immediately.
- Write effect: a write at edge n is visible to a stage-1 read at edge n+1 (`WR_BYPASS=0`), or at edge n (`WR_BYPASS=1`).
- `lut_ready`:
  - Rises the cycle after the last missing entry's write edge.
  - Falls the cycle after `load_clr`.
  - Rewrites do not affect it.
- Address wrap: none; `ADDR_W` covers the full space exactly.

## Test plan
- **Reset.** Drive `rstn` low mid-stream with `in_valid=4'hF` → all outputs 0 at once. After release with no writes, reads of any address return 0 and `lut_ready=0`.
- **Basic read.** Q=3, mode 0. Write `addr 5'b01101 = 3'b110`. Port 0: `y0=3'b001`, `y1=3'b101`, `transpose_en_in=0` → two cycles later `t_c_out[2:0]=3'b110`, `transpose_en_out[0]=0`, `out_valid[0]=1`.
- **Sign fold.**
  - Mode 0, port 1: `y0=3'b101`, `y1=3'b010` → same address 13 → `3'b110`, `transpose_en_out[1]=1`.
  - Same stimulus with `transpose_en_in=1` → sign 0, `y1` not inverted, address `5'b01010`.
  - Mode 1, `y0=3'b110` → `y0m=2'b01`.
- **All ports, one cycle.** Four distinct addresses loaded with 1, 2, 3, 4 → each port returns its own value at cycle n+2. Streaming 8 back-to-back cycles gives `out_valid` continuous for 8 cycles.
- **Collision.** `we` on address 13 with data 3'b011 while a stage-1 read targets address 13 (old entry 3'b110) → returns 3'b110 when `WR_BYPASS=0`, 3'b011 when `WR_BYPASS=1`. The next read returns 3'b011 in both cases.
- **Load tracking.** Write 31 of 32 entries → `lut_ready=0`. Write the last one → `lut_ready=1` the next cycle. Pulse `load_clr` together with `we` → `lut_ready=0` and the written bit stays clear.
